// File: rtl/axi_tensor_wr.sv
// AXI4 write master for tensorcore result tiles: one burst at a time, AW then W
// beats passed straight through from the compute core, then B with done/err.
module axi_tensor_wr #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned MAX_BURST  = 256
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]              cmd_len,
  input  logic [2:0]              cmd_size,
  input  logic [DATA_WIDTH-1:0]   s_dat,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [ID_WIDTH-1:0]     m_axi_awid,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  localparam logic [8:0] LEN_MAX = 9'(MAX_BURST - 1);

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              len_q;
  logic [2:0]              size_q;
  logic [7:0]              cnt_q;
  logic                    done_q;
  logic                    err_q;

  logic [7:0]              len_d;
  logic                    last_beat;
  logic                    w_hs;
  logic                    unused_bits;

  // Over-long lengths are illegal from the caller; clamping keeps WLAST reachable.
  assign len_d     = ({1'b0, cmd_len} > LEN_MAX) ? LEN_MAX[7:0] : cmd_len;
  assign last_beat = (cnt_q == len_q);
  assign w_hs      = (state_q == DATA) && s_valid && m_axi_wready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            addr_q  <= cmd_addr;
            len_q   <= len_d;
            size_q  <= cmd_size;
            cnt_q   <= '0;
            state_q <= ADDR;
          end
        end
        ADDR: begin
          if (m_axi_awready) state_q <= DATA;
        end
        DATA: begin
          if (w_hs) begin
            if (last_beat) state_q <= RESP;
            else           cnt_q   <= cnt_q + 8'd1;
          end
        end
        RESP: begin
          if (m_axi_bvalid) begin
            done_q  <= 1'b1;
            err_q   <= m_axi_bresp[1];
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready     = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign err           = err_q;

  assign m_axi_awid    = '0;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = size_q;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awvalid = (state_q == ADDR);

  // W is a zero-latency pass-through of the compute stream while in DATA.
  assign m_axi_wdata   = s_dat;
  assign m_axi_wstrb   = '1;
  assign m_axi_wvalid  = (state_q == DATA) && s_valid;
  assign m_axi_wlast   = (state_q == DATA) && last_beat;
  assign s_ready       = (state_q == DATA) && m_axi_wready;

  assign m_axi_bready  = (state_q == RESP);

  assign unused_bits   = ^{m_axi_bid, m_axi_bresp[0]};

endmodule

// File: tb/tb_axi_tensor_wr.sv
// Scoreboard bench for axi_tensor_wr: stimulus queues expected AW/W/B results,
// a negedge monitor pops and compares them as the DUT presents handshakes.
module tb_axi_tensor_wr;

  localparam int AW = 32;
  localparam int DW = 256;
  localparam int IW = 4;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic            cmd_valid, cmd_ready;
  logic [AW-1:0]   cmd_addr;
  logic [7:0]      cmd_len;
  logic [2:0]      cmd_size;
  logic [DW-1:0]   s_dat;
  logic            s_valid, s_ready;
  logic [IW-1:0]   m_axi_awid;
  logic [AW-1:0]   m_axi_awaddr;
  logic [7:0]      m_axi_awlen;
  logic [2:0]      m_axi_awsize;
  logic [1:0]      m_axi_awburst;
  logic            m_axi_awvalid, m_axi_awready;
  logic [DW-1:0]   m_axi_wdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic            m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [IW-1:0]   m_axi_bid;
  logic [1:0]      m_axi_bresp;
  logic            m_axi_bvalid, m_axi_bready;
  logic            busy, done, err;

  always #5 aclk = ~aclk;

  axi_tensor_wr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_BURST(256)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_size(cmd_size),
    .s_dat(s_dat), .s_valid(s_valid), .s_ready(s_ready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [2:0]    size;
  } aw_exp_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } w_exp_t;

  aw_exp_t aw_q[$];
  w_exp_t  w_q[$];
  logic    b_q[$];

  int n_cmp = 0;
  int n_err = 0;

  int       aw_delay   = 0;
  int       w_stall_at = -1;
  logic [1:0] bresp_cfg = 2'b00;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got unexpected/missing event, required none", name);
  endtask

  function automatic logic [DW-1:0] beat_data(input int b, input int i);
    logic [31:0] w;
    w = 32'hA000_0000 | (32'(b) << 16) | 32'(i);
    return {(DW/32){w}};
  endfunction

  // AW slave: hold awready low for aw_delay cycles of awvalid
  initial begin
    int waited = 0;
    m_axi_awready = 1'b0;
    forever begin
      @(posedge aclk); #1;
      if (!aresetn || !m_axi_awvalid) begin
        m_axi_awready = 1'b0;
        waited = 0;
      end else if (waited >= aw_delay) begin
        m_axi_awready = 1'b1;
      end else begin
        m_axi_awready = 1'b0;
        waited++;
      end
    end
  end

  // W slave: three-cycle wready stall once w_stall_at beats of a burst are taken
  initial begin
    int   wbeats = 0;
    int   stall_cnt = 0;
    logic hs, hs_last;
    m_axi_wready = 1'b1;
    forever begin
      @(negedge aclk);
      hs = m_axi_wvalid && m_axi_wready;
      hs_last = m_axi_wlast;
      @(posedge aclk); #1;
      if (!aresetn) begin
        wbeats = 0;
        stall_cnt = 0;
        m_axi_wready = 1'b1;
      end else begin
        if (hs) wbeats = hs_last ? 0 : wbeats + 1;
        if (wbeats == w_stall_at && stall_cnt < 3) begin
          m_axi_wready = 1'b0;
          stall_cnt++;
        end else begin
          m_axi_wready = 1'b1;
          if (wbeats != w_stall_at) stall_cnt = 0;
        end
      end
    end
  end

  // B slave: respond one cycle after bready rises
  initial begin
    m_axi_bvalid = 1'b0;
    m_axi_bresp  = 2'b00;
    m_axi_bid    = '0;
    forever begin
      @(posedge aclk); #1;
      if (!aresetn)          m_axi_bvalid = 1'b0;
      else if (m_axi_bvalid) m_axi_bvalid = 1'b0;
      else if (m_axi_bready) begin
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = bresp_cfg;
      end
    end
  end

  // Monitor
  initial begin
    logic b_hs_prev = 1'b0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        b_hs_prev = 1'b0;
      end else begin
        if (m_axi_awvalid) begin
          chk("aw_no_wvalid", DW'(m_axi_wvalid), '0);
          chk("aw_no_sready", DW'(s_ready), '0);
          if (aw_q.size() == 0) fail_evt("aw_unexpected");
          else begin
            chk("awaddr", DW'(m_axi_awaddr), DW'(aw_q[0].addr));
            chk("awlen", DW'(m_axi_awlen), DW'(aw_q[0].len));
            chk("awsize", DW'(m_axi_awsize), DW'(aw_q[0].size));
            chk("awid", DW'(m_axi_awid), '0);
            chk("awburst", DW'(m_axi_awburst), DW'(2'b01));
            if (m_axi_awready) void'(aw_q.pop_front());
          end
        end
        if (m_axi_wvalid) begin
          if (w_q.size() == 0) fail_evt("w_unexpected");
          else begin
            chk("wdata", m_axi_wdata, w_q[0].data);
            chk("wlast", DW'(m_axi_wlast), DW'(w_q[0].last));
            chk("wstrb", DW'(m_axi_wstrb), DW'({(DW/8){1'b1}}));
            if (m_axi_wready) void'(w_q.pop_front());
            else chk("stall_sready", DW'(s_ready), '0);
          end
        end
        if (b_hs_prev || done) chk("done_timing", DW'(done), DW'(b_hs_prev));
        if (done) begin
          if (b_q.size() == 0) fail_evt("done_unexpected");
          else chk("err", DW'(err), DW'(b_q.pop_front()));
        end
        b_hs_prev = m_axi_bvalid && m_axi_bready;
      end
    end
  end

  task automatic start_burst(input int b, input logic [AW-1:0] addr, input int len,
                             input logic [2:0] size, input logic err_exp);
    aw_exp_t a;
    w_exp_t  w;
    a.addr = addr; a.len = 8'(len); a.size = size;
    aw_q.push_back(a);
    for (int i = 0; i <= len; i++) begin
      w.data = beat_data(b, i);
      w.last = (i == len);
      w_q.push_back(w);
    end
    b_q.push_back(err_exp);
    @(posedge aclk); #1;
    cmd_valid = 1'b1; cmd_addr = addr; cmd_len = 8'(len); cmd_size = size;
    @(negedge aclk);
    chk("cmd_ready", DW'(cmd_ready), DW'(1));
    @(posedge aclk); #1;
    cmd_valid = 1'b0;
    @(negedge aclk);
    chk("aw_latency", DW'(m_axi_awvalid), DW'(1));
    chk("busy_addr", DW'(busy), DW'(1));
  endtask

  task automatic feed(input int b, input int i, input bit toggle);
    logic got = 1'b0;
    if (i == 0) begin @(posedge aclk); #1; end
    s_valid = 1'b1;
    s_dat   = beat_data(b, i);
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge aclk);
      got = s_ready;
      @(posedge aclk); #1;
    end
    if (!got) fail_evt("feed_timeout");
    if (toggle) begin
      s_valid = 1'b0;
      @(posedge aclk); #1;
    end
  endtask

  task automatic finish_burst();
    logic got = 1'b0;
    s_valid = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge aclk);
      got = done;
    end
    if (!got) fail_evt("done_timeout");
    chk("busy_idle", DW'(busy), '0);
    chk("cmd_ready_after", DW'(cmd_ready), DW'(1));
  endtask

  task automatic run_burst(input int b, input logic [AW-1:0] addr, input int len,
                           input logic [2:0] size, input logic err_exp, input bit toggle);
    start_burst(b, addr, len, size, err_exp);
    for (int i = 0; i <= len; i++) feed(b, i, toggle);
    finish_burst();
    $display("burst %0d addr=%h len=%0d done", b, addr, len);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_size = '0;
    s_valid = 1'b0; s_dat = '0;
    #2;
    chk("rst_cmd_ready", DW'(cmd_ready), DW'(1));
    chk("rst_awvalid", DW'(m_axi_awvalid), '0);
    chk("rst_wvalid", DW'(m_axi_wvalid), '0);
    chk("rst_bready", DW'(m_axi_bready), '0);
    chk("rst_busy", DW'(busy), '0);
    chk("rst_done", DW'(done), '0);
    chk("rst_awaddr", DW'(m_axi_awaddr), '0);
    @(posedge aclk); @(posedge aclk); #1;
    aresetn = 1'b1;

    run_burst(1, 32'h0000_1000, 0, 3'd5, 1'b0, 1'b0);
    run_burst(2, 32'h0000_2000, 15, 3'd5, 1'b0, 1'b1);
    aw_delay = 5;
    run_burst(3, 32'h0000_3000, 3, 3'd5, 1'b0, 1'b0);
    aw_delay = 0;
    w_stall_at = 4;
    run_burst(4, 32'h0000_4000, 7, 3'd5, 1'b0, 1'b0);
    w_stall_at = -1;
    bresp_cfg = 2'b10;
    run_burst(5, 32'h0000_5000, 1, 3'd4, 1'b1, 1'b0);
    bresp_cfg = 2'b00;
    run_burst(6, 32'h0000_6000, 0, 3'd5, 1'b0, 1'b0);
    bresp_cfg = 2'b11;
    run_burst(7, 32'h0000_7000, 0, 3'd5, 1'b1, 1'b0);
    bresp_cfg = 2'b00;

    // Abandon a burst after three of eight beats
    start_burst(8, 32'h0000_8000, 7, 3'd5, 1'b0);
    for (int i = 0; i < 3; i++) feed(8, i, 1'b0);
    s_valid = 1'b1;
    s_dat   = beat_data(8, 3);
    #2;
    aresetn = 1'b0;
    #1;
    chk("mid_rst_cmd_ready", DW'(cmd_ready), DW'(1));
    chk("mid_rst_wvalid", DW'(m_axi_wvalid), '0);
    chk("mid_rst_wlast", DW'(m_axi_wlast), '0);
    chk("mid_rst_sready", DW'(s_ready), '0);
    chk("mid_rst_awvalid", DW'(m_axi_awvalid), '0);
    chk("mid_rst_bready", DW'(m_axi_bready), '0);
    chk("mid_rst_busy", DW'(busy), '0);
    chk("mid_rst_done", DW'(done), '0);
    chk("mid_rst_err", DW'(err), '0);
    chk("mid_rst_awaddr", DW'(m_axi_awaddr), '0);
    chk("mid_rst_awlen", DW'(m_axi_awlen), '0);
    chk("mid_rst_awsize", DW'(m_axi_awsize), '0);
    $display("reset asserted mid-burst after 3 beats");
    s_valid = 1'b0;
    w_q.delete();
    b_q.delete();
    aw_q.delete();
    @(posedge aclk); @(posedge aclk); #1;
    aresetn = 1'b1;
    @(negedge aclk);
    chk("post_rst_cmd_ready", DW'(cmd_ready), DW'(1));
    chk("post_rst_busy", DW'(busy), '0);

    run_burst(9, 32'h0000_9000, 255, 3'd5, 1'b0, 1'b0);

    repeat (3) @(negedge aclk);
    chk("aw_q_empty", DW'(aw_q.size()), '0);
    chk("w_q_empty", DW'(w_q.size()), '0);
    chk("b_q_empty", DW'(b_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
